// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: ROM read port, decode valid/ready handshake and redirect bundle
interface instr_fetch_unit_if;
   logic [15:0] rom_addr;
   logic        rom_oe;
   logic [31:0] rom_data;
   logic [31:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;
   modport master (
      output rom_addr, rom_oe, instr, instr_pc, instr_valid,
      input  rom_data, instr_ready, redirect, redirect_pc
   );
   modport slave (
      input  rom_addr, rom_oe, instr, instr_pc, instr_valid,
      output rom_data, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, ROM fetch and two-entry instruction buffer feeding decode
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h8000,
   parameter logic [15:0] ROM_BASE = 16'h8000,
   parameter logic [15:0] ROM_LAST = 16'h8FFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_en,
   output logic                fault,
   instr_fetch_unit_if.master  bus
);
   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [1:0]  r_cnt, w_cnt_nxt;
   logic [47:0] r_e0, r_e1, w_e0_nxt, w_e1_nxt, w_new;
   logic        w_fetch, w_pop, w_in_win;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_cnt   <= 2'd0;
         r_e0    <= 48'h0;
         r_e1    <= 48'h0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_e0    <= w_e0_nxt;
         r_e1    <= w_e1_nxt;
      end
   end
   // entry 0 is always the head; each entry is {instruction, pc}
   always_comb begin
      w_in_win    = bus.redirect_pc >= ROM_BASE && bus.redirect_pc <= ROM_LAST;
      w_fetch     = r_state == RUN && fetch_en && !bus.redirect && r_cnt != 2'd2;
      w_pop       = r_cnt != 2'd0 && bus.instr_ready;
      w_new       = {bus.rom_data, r_pc};
      w_state_nxt = bus.redirect ? (w_in_win ? RUN : FAULT) :
                    (r_state == IDLE && fetch_en) ? RUN : r_state;
      w_pc_nxt    = bus.redirect ? bus.redirect_pc :
                    !w_fetch ? r_pc : (r_pc == ROM_LAST ? ROM_BASE : r_pc + 16'd1);
      w_cnt_nxt   = bus.redirect ? 2'd0 : r_cnt + {1'b0, w_fetch} - {1'b0, w_pop};
      w_e0_nxt    = w_pop ? (r_cnt == 2'd2 ? r_e1 : w_new) : (r_cnt == 2'd0 ? w_new : r_e0);
      w_e1_nxt    = (w_fetch && !w_pop && r_cnt == 2'd1) ? w_new : r_e1;
   end
   assign bus.rom_addr    = r_pc;
   assign bus.rom_oe      = w_fetch;
   assign bus.instr_valid = r_cnt != 2'd0;
   assign bus.instr       = bus.instr_valid ? r_e0[47:16] : 32'h0;
   assign bus.instr_pc    = bus.instr_valid ? r_e0[15:0] : 16'h0;
   assign fault           = r_state == FAULT;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized fetch traffic checked against a queue model
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic fetch_en = 1'b0;
   logic fault;
   int   total = 0;
   int   bad = 0;
   int   oe_cnt = 0;
   logic [47:0] q[$];
   logic [15:0] m_pc;
   int   m_st;
   instr_fetch_unit_if bus();
   instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .fault(fault), .bus(bus));
   always #5 clk = ~clk;
   always_comb bus.rom_data = bus.rom_oe ? {16'hA5A5, bus.rom_addr} : 32'hz;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      q.delete();
      m_pc = 16'h8000;
      m_st = 0;
   endtask
   // one clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1
   task automatic cycle(input logic fen, input logic rdy, input logic rd, input logic [15:0] rpc);
      logic        exp_fetch;
      logic [47:0] h;
      fetch_en = fen;
      bus.instr_ready = rdy;
      bus.redirect = rd;
      bus.redirect_pc = rpc;
      #4;
      exp_fetch = m_st == 1 && fen && !rd && q.size() < 2;
      h = q.size() > 0 ? q[0] : 48'h0;
      check("rom_oe", 64'(bus.rom_oe), 64'(exp_fetch));
      check("rom_addr", 64'(bus.rom_addr), 64'(m_pc));
      check("instr_valid", 64'(bus.instr_valid), 64'(q.size() > 0));
      check("instr", 64'(bus.instr), 64'(h[47:16]));
      check("instr_pc", 64'(bus.instr_pc), 64'(h[15:0]));
      check("fault", 64'(fault), 64'(m_st == 2));
      check("oe_on_z", 64'(bus.rom_oe && $isunknown(bus.rom_data)), 64'd0);
      if (bus.rom_oe) oe_cnt++;
      if (rd) begin
         q.delete();
         m_pc = rpc;
         m_st = (rpc >= 16'h8000 && rpc <= 16'h8FFF) ? 1 : 2;
      end else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (exp_fetch) begin
            q.push_back({16'hA5A5, m_pc, m_pc});
            m_pc = (m_pc == 16'h8FFF) ? 16'h8000 : m_pc + 16'd1;
         end
         if (m_st == 0 && fen) m_st = 1;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic async_reset();
      fetch_en = 1'b0;
      bus.redirect = 1'b0;
      bus.instr_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_addr", 64'(bus.rom_addr), 64'h8000);
      check("rst_oe", 64'(bus.rom_oe), 64'd0);
      check("rst_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_instr", 64'(bus.instr), 64'd0);
      check("rst_pc", 64'(bus.instr_pc), 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      model_reset();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic        fen, rdy, rd;
      logic [15:0] rpc;
      bus.instr_ready = 1'b0;
      bus.redirect = 1'b0;
      bus.redirect_pc = 16'h0;
      model_reset();
      @(posedge clk);
      #1;
      async_reset();
      oe_cnt = 0;
      repeat (7) cycle(1, 0, 0, 16'h0);
      check("stall_pulses", 64'(oe_cnt), 64'd2);
      repeat (6) cycle(1, 1, 0, 16'h0);
      repeat (3) cycle(1, 0, 0, 16'h0);
      cycle(1, 0, 1, 16'h8FFE);
      repeat (6) cycle(1, 1, 0, 16'h0);
      cycle(1, 1, 1, 16'h1234);
      oe_cnt = 0;
      repeat (10) cycle(1, 1, 0, 16'h0);
      check("fault_pulses", 64'(oe_cnt), 64'd0);
      cycle(1, 1, 1, 16'h8010);
      repeat (5) cycle(1, 1, 0, 16'h0);
      async_reset();
      repeat (3) cycle(0, 1, 0, 16'h0);
      repeat (5) cycle(1, 1, 0, 16'h0);
      cycle(1, 1, 1, 16'h8100);
      repeat (4) cycle(1, 1, 0, 16'h0);
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 149) == 0) async_reset();
         fen = $urandom_range(0, 9) != 0;
         rdy = $urandom_range(0, 9) < 6;
         rd  = $urandom_range(0, 19) == 0;
         case ($urandom_range(0, 3))
            0:       rpc = 16'($urandom);
            1:       rpc = 16'h8FFE + 16'($urandom_range(0, 1));
            default: rpc = 16'h8000 + 16'($urandom_range(0, 16'h0FFF));
         endcase
         cycle(fen, rdy, rd, rpc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
